// File: rtl/ssd_pkg.sv
// Purpose: shared constants, state encoding and helpers for the seven-segment driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ssd_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ANODE_OFF = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 so the
    // following left shift carries correctly into the next decade.
    function automatic logic [15:0] dabble_adj(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int k = 0; k < 4; k++) begin
            if (bcd[k*4 +: 4] >= 4'd5) begin
                res[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    // Nibbles above 9 cannot come out of a correct conversion; they show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_driver_if.sv
// Purpose: groups the value/load/busy handshake and the display pins of ssd_driver.
// Latency: n/a (wiring only).
// Backpressure: busy high means load is ignored; no queueing.
// Ports: value/load driven by the producer (master); busy, anode, cathode, dp
//        driven by the display driver (slave).
interface ssd_driver_if #(
    parameter int VAL_W = 13
);
    logic [VAL_W-1:0] value;
    logic             load;
    logic             busy;
    logic [3:0]       anode;
    logic [6:0]       cathode;
    logic             dp;

    modport master (
        output value, load,
        input  busy, anode, cathode, dp
    );

    modport slave (
        input  value, load,
        output busy, anode, cathode, dp
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential binary-to-BCD converter (shift-add-3) with an atomic output register.
// Latency: load at edge N -> o_bcd updated and o_busy low at edge N+VAL_W.
// Backpressure: i_load is ignored while o_busy is high; nothing is queued.
// Ports: clk, rst (async active-low), i_value/i_load in, o_busy and o_bcd (4 BCD digits) out.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int VAL_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] i_value,
    input  logic             i_load,
    output logic             o_busy,
    output logic [15:0]      o_bcd
);

    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(VAL_W - 1);

    state_t             r_state;
    logic [VAL_W-1:0]   r_bin;
    logic [15:0]        r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [15:0]        r_bcd;

    logic [15:0]        w_adj;
    logic [VAL_W+15:0]  w_shift;
    logic [15:0]        w_next_scratch;
    logic [VAL_W-1:0]   w_next_bin;

    // One iteration of the algorithm, computed combinationally so the final
    // iteration can be written straight into the display register.
    assign w_adj          = dabble_adj(r_scratch);
    assign w_shift        = {w_adj, r_bin} << 1;
    assign w_next_scratch = w_shift[VAL_W+15:VAL_W];
    assign w_next_bin     = w_shift[VAL_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_bin     <= i_value;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    if (r_cnt == LAST_IT) begin
                        // Only the finished result ever reaches r_bcd.
                        r_bcd   <= w_next_scratch;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_scratch <= w_next_scratch;
                        r_bin     <= w_next_bin;
                        r_cnt     <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/ssd_driver.sv
// Purpose: 4-digit common-anode seven-segment driver: binary in, BCD convert, multiplexed scan out.
// Latency: display reflects a load VAL_W cycles later; anode/cathode lag the digit index by one cycle.
// Backpressure: busy high while converting; loads during busy are dropped.
// Ports: clk, rst (async active-low), bus (slave modport: value/load in; busy, anode,
//        cathode, dp out).
module ssd_driver
    import ssd_pkg::*;
#(
    parameter int VAL_W        = 13,
    parameter int REFRESH_BITS = 18,
    parameter int BLANK_LZ     = 1
) (
    input  logic         clk,
    input  logic         rst,
    ssd_driver_if.slave  bus
);

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [3:0]              r_anode;
    logic [6:0]              r_cathode;

    logic [15:0]             w_bcd;
    logic                    w_busy;
    logic [1:0]              w_idx;
    logic [3:0]              w_digit;
    logic                    w_lz;
    logic                    w_blank;

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .i_value (bus.value),
        .i_load  (bus.load),
        .o_busy  (w_busy),
        .o_bcd   (w_bcd)
    );

    assign w_idx   = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_digit = w_bcd[w_idx*4 +: 4];

    // A digit is a leading zero when it and every digit to its left are zero.
    // The rightmost digit always shows, so a value of 0 reads "0".
    always_comb begin
        w_lz = 1'b0;
        case (w_idx)
            2'd3: w_lz = (w_bcd[15:12] == 4'd0);
            2'd2: w_lz = (w_bcd[15:8]  == 8'd0);
            2'd1: w_lz = (w_bcd[15:4]  == 12'd0);
            default: w_lz = 1'b0;
        endcase
    end

    assign w_blank = (BLANK_LZ != 0) && w_lz;

    // Anode and cathode share one register stage so they switch on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh <= '0;
            r_anode   <= ANODE_OFF;
            r_cathode <= SEG_BLANK;
        end else begin
            r_refresh <= r_refresh + 1'b1;
            r_anode   <= ~(4'b0001 << w_idx);
            r_cathode <= w_blank ? SEG_BLANK : seg_decode(w_digit);
        end
    end

    assign bus.busy    = w_busy;
    assign bus.anode   = r_anode;
    assign bus.cathode = r_cathode;
    assign bus.dp      = 1'b1;

    a_digit_legal: assert property (@(posedge clk) disable iff (!rst) (w_digit <= 4'd9))
        else $error("ssd_driver: illegal BCD nibble %0d on digit %0d", w_digit, w_idx);

endmodule
